// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one 16->32 immediate extender between decode (0) and branch (1),
// with a one-entry valid/ready output register. Define IMM_EXT_LUI_EN to enable upper (LUI) mode.
module imm_ext_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_imm0,
  input  logic [15:0]      req_imm1,
  input  logic [1:0]       req_mode0,
  input  logic [1:0]       req_mode1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic [31:0]      r_data;
  logic             r_id;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_slot_free;
  logic             w_xfer;
  logic             w_grant;
  logic [15:0]      w_imm;
  logic [1:0]       w_mode;
  logic [31:0]      w_sext;
  logic [31:0]      w_ext;
  logic             w_bad;

  // NOTE: every signal gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_grant     = r_last_grant;
    req_ready   = 2'b00;
    // A full slot is free again when the consumer drains it this cycle.
    w_slot_free = (r_state == S_EMPTY) || rsp_ready;

    if (w_slot_free) begin
      unique case (req_valid)
        2'b01:   begin w_xfer = 1'b1; w_grant = 1'b0;          end
        2'b10:   begin w_xfer = 1'b1; w_grant = 1'b1;          end
        2'b11:   begin w_xfer = 1'b1; w_grant = ~r_last_grant; end
        default: ;
      endcase
    end

    if (w_xfer) begin
      req_ready   = w_grant ? 2'b10 : 2'b01;
      w_state_nxt = S_FULL;
    end else if (rsp_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_comb begin
    w_imm  = w_grant ? req_imm1  : req_imm0;
    w_mode = w_grant ? req_mode1 : req_mode0;
    w_sext = {{16{w_imm[15]}}, w_imm};
    w_ext  = w_sext;
    w_bad  = 1'b0;
    unique case (w_mode)
      2'b00: w_ext = w_sext;
      2'b01: w_ext = {16'h0000, w_imm};
`ifdef IMM_EXT_LUI_EN
      2'b10: w_ext = {w_imm, 16'h0000};
`else
      2'b10: begin w_ext = w_sext; w_bad = 1'b1; end
`endif
      default: begin w_ext = w_sext; w_bad = 1'b1; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_last_grant <= 1'b1;
      r_data       <= 32'h0;
      r_id         <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_data       <= w_ext;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
        if (w_bad && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter: directed scenarios then randomized traffic,
// checked against a behavioural model of arbitration, extension and error counting.
module tb_imm_ext_arbiter;

  localparam int CW      = 2;
  localparam int ERR_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [15:0]   req_imm0, req_imm1;
  logic [1:0]    req_mode0, req_mode1;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_id;
  logic [CW-1:0] err_cnt;

  imm_ext_arbiter #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_imm0  (req_imm0),
    .req_imm1  (req_imm1),
    .req_mode0 (req_mode0),
    .req_mode1 (req_mode1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .err_cnt   (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    logic        id;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mode_bad(input logic [1:0] mode);
`ifdef IMM_EXT_LUI_EN
    return mode == 2'b11;
`else
    return mode[1];
`endif
  endfunction

  function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic [1:0] mode);
    if (mode == 2'b01) return 32'(imm);
    if (mode == 2'b10 && !mode_bad(mode)) return 32'(imm) << 16;
    return 32'($signed(imm));
  endfunction

  // Reference model: result slot occupancy, last winner and error count.
  logic       m_full;
  logic       m_last;
  int         m_err;
  logic [1:0] exp_ready;

  always begin : model
    logic  exp_xfer;
    logic  exp_id;
    item_t it;
    @(negedge clk);
    exp_xfer  = 1'b0;
    exp_id    = 1'b0;
    exp_ready = 2'b00;
    it.data   = 32'h0;
    it.id     = 1'b0;
    if (!rst_n) begin
      m_full <= 1'b0;
      m_last <= 1'b1;
      m_err  <= 0;
    end else begin
      if ((!m_full || rsp_ready) && req_valid != 2'b00) begin
        exp_xfer  = 1'b1;
        exp_id    = (req_valid == 2'b11) ? !m_last : req_valid[1];
        exp_ready = exp_id ? 2'b10 : 2'b01;
        it.id     = exp_id;
        it.data   = exp_id ? ext_ref(req_imm1, req_mode1) : ext_ref(req_imm0, req_mode0);
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
    end
    @(posedge clk);
    if (rst_n) begin
      if (exp_xfer) begin
        exp_q.push_back(it);
        m_last <= exp_id;
        m_full <= 1'b1;
        if (mode_bad(exp_id ? req_mode1 : req_mode0) && m_err < ERR_MAX) m_err <= m_err + 1;
      end else if (rsp_ready) begin
        m_full <= 1'b0;
      end
    end
  end

  // Monitor: compares the held result against the oldest outstanding expectation.
  int rd_idx = 0;
  always @(negedge clk) begin
    int pend;
    if (!rst_n) begin
      rd_idx = exp_q.size();
    end else begin
      pend = exp_q.size() - rd_idx;
      check("rsp_valid", 32'(rsp_valid), 32'(pend > 0));
      check("err_cnt", 32'(err_cnt), 32'(m_err));
      if (pend > 0 && rsp_valid) begin
        check("rsp_data", rsp_data, exp_q[rd_idx].data);
        check("rsp_id", 32'(rsp_id), 32'(exp_q[rd_idx].id));
        if (rsp_ready) rd_idx++;
      end
    end
  end

  task automatic cyc(input logic [1:0] v, input logic [15:0] i0, input logic [1:0] m0,
                     input logic [15:0] i1, input logic [1:0] m1, input logic rdy);
    req_valid = v;
    req_imm0  = i0;
    req_mode0 = m0;
    req_imm1  = i1;
    req_mode1 = m1;
    rsp_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0]  v;
    logic [15:0] i0, i1;
    logic [1:0]  m0, m1;
    rst_n = 1'b0;
    req_valid = 2'b00; req_imm0 = '0; req_imm1 = '0;
    req_mode0 = '0; req_mode1 = '0; rsp_ready = 1'b0;
    #1;
    check("init_valid", 32'(rsp_valid), 32'h0);
    check("init_data", rsp_data, 32'h0);
    check("init_id", 32'(rsp_id), 32'h0);
    check("init_err", 32'(err_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requests with the consumer always ready.
    cyc(2'b01, 16'h8001, 2'b00, 16'h0, 2'b00, 1'b1);
    cyc(2'b01, 16'h8001, 2'b01, 16'h0, 2'b00, 1'b1);
    cyc(2'b10, 16'h0, 2'b00, 16'h1234, 2'b10, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Contention: alternating grants, one result per cycle.
    for (int k = 0; k < 6; k++)
      cyc(2'b11, 16'(16'h0100 + k), 2'b00, 16'(16'hF000 + k), 2'b01, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Backpressure: result held, both requesters stalled, then resume.
    cyc(2'b01, 16'hABCD, 2'b00, 16'h0, 2'b00, 1'b1);
    for (int k = 0; k < 5; k++)
      cyc(2'b11, 16'h1111, 2'b01, 16'h8222, 2'b00, 1'b0);
    cyc(2'b11, 16'h1111, 2'b01, 16'h8222, 2'b00, 1'b1);
    cyc(2'b01, 16'h1111, 2'b01, 16'h8222, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Reset while holding a result, then the first tie goes to requester 0.
    cyc(2'b01, 16'h7FFF, 2'b11, 16'h0, 2'b00, 1'b0);
    check("pre_rst_valid", 32'(rsp_valid), 32'(m_full));
    async_reset();
    cyc(2'b11, 16'h0042, 2'b00, 16'h0043, 2'b00, 1'b1);
    cyc(2'b10, 16'h0042, 2'b00, 16'h0043, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Reserved-mode errors saturate.
    for (int k = 0; k < 5; k++)
      cyc(2'b01, 16'(16'h8000 + k), 2'b11, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Upper mode alone: error only when LUI support is built out.
    async_reset();
    cyc(2'b10, 16'h0, 2'b00, 16'h1234, 2'b10, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b0);

    // Randomized traffic; a requester holds its payload until the model says it was accepted.
    v = 2'b00; i0 = '0; i1 = '0; m0 = '0; m1 = '0;
    for (int k = 0; k < 400; k++) begin
      if (!(v[0] && !exp_ready[0])) begin
        v[0] = ($urandom_range(0, 99) < 60);
        i0   = 16'($urandom);
        m0   = 2'($urandom_range(0, 3));
      end
      if (!(v[1] && !exp_ready[1])) begin
        v[1] = ($urandom_range(0, 99) < 60);
        i1   = 16'($urandom);
        m1   = 2'($urandom_range(0, 3));
      end
      cyc(v, i0, m0, i1, m1, ($urandom_range(0, 99) < 70));
    end
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
